// File: rtl/synapse_scheduler.sv
// synapse_scheduler: delays spikes from N_IN presynaptic lines by a
// per-channel programmable axonal delay, then serialises the expired spikes
// onto one postsynaptic line through a round-robin arbiter.
// Optional feature: define SYN_DROP_COUNT_EN to add the 8-bit saturating
// drop_count output.
module synapse_scheduler #(
    parameter int N_IN    = 4,
    parameter int DELAY_W = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_IN-1:0]    spike_in,
    input  logic               cfg_we,
    input  logic [ID_W-1:0]    cfg_addr,
    input  logic [DELAY_W-1:0] cfg_delay,
    output logic               spike_out,
    output logic [ID_W-1:0]    spike_id,
    output logic [N_IN-1:0]    busy,
    output logic               drop_pulse
`ifdef SYN_DROP_COUNT_EN
    ,
    output logic [7:0]         drop_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t             r_state     [N_IN];
    state_t             w_state_nxt [N_IN];
    logic [DELAY_W-1:0] r_cnt       [N_IN];
    logic [DELAY_W-1:0] w_cnt_nxt   [N_IN];
    logic [DELAY_W-1:0] r_delay     [N_IN];

    logic [N_IN-1:0]    r_prev;
    logic [N_IN-1:0]    w_edge;
    logic [N_IN-1:0]    w_req;
    logic [N_IN-1:0]    w_gnt;
    logic [N_IN-1:0]    w_drop;
    logic               w_gnt_vld;
    logic [ID_W-1:0]    w_gnt_idx;
    logic [ID_W-1:0]    r_ptr;
    logic               r_spike_out;
    logic [ID_W-1:0]    r_spike_id;
    logic               r_drop_pulse;

    // A level held high yields a single rising-edge event.
    assign w_edge = spike_in & ~r_prev;

    // Request and busy flags come straight from channel state.
    always_comb begin
        w_req = '0;
        busy  = '0;
        for (int i = 0; i < N_IN; i++) begin
            w_req[i] = (r_state[i] == ST_READY);
            busy[i]  = (r_state[i] != ST_IDLE);
        end
    end

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        int idx;
        idx       = 0;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_gnt     = '0;
        for (int k = 1; k <= N_IN; k++) begin
            idx = (int'(r_ptr) + k) % N_IN;
            if (!w_gnt_vld && w_req[idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = idx[ID_W-1:0];
            end
        end
        if (w_gnt_vld) begin
            w_gnt[w_gnt_idx] = 1'b1;
        end
    end

    // Per-channel next state: load delay on an accepted edge, count down,
    // wait for a grant; any edge while not idle is dropped.
    always_comb begin
        w_drop = '0;
        for (int i = 0; i < N_IN; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            case (r_state[i])
                ST_IDLE: begin
                    if (w_edge[i]) begin
                        if (r_delay[i] == '0) begin
                            w_state_nxt[i] = ST_READY;
                        end else begin
                            w_state_nxt[i] = ST_DELAY;
                            w_cnt_nxt[i]   = r_delay[i];
                        end
                    end
                end
                ST_DELAY: begin
                    w_drop[i] = w_edge[i];
                    if (r_cnt[i] == DELAY_W'(1)) begin
                        w_state_nxt[i] = ST_READY;
                        w_cnt_nxt[i]   = '0;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] - DELAY_W'(1);
                    end
                end
                ST_READY: begin
                    w_drop[i] = w_edge[i];
                    if (w_gnt[i]) begin
                        w_state_nxt[i] = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt[i] = ST_IDLE;
                    w_cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    // Channel state and delay counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
        end
    end

    // Delay registers; a write lands after this edge's load, so a
    // same-cycle edge still uses the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) begin
                r_delay[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (cfg_we && (cfg_addr == ID_W'(i))) begin
                    r_delay[i] <= cfg_delay;
                end
            end
        end
    end

    // Edge history, arbiter pointer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev       <= '0;
            r_ptr        <= ID_W'(N_IN - 1);
            r_spike_out  <= 1'b0;
            r_spike_id   <= '0;
            r_drop_pulse <= 1'b0;
        end else begin
            r_prev       <= spike_in;
            r_spike_out  <= w_gnt_vld;
            r_drop_pulse <= |w_drop;
            if (w_gnt_vld) begin
                r_ptr      <= w_gnt_idx;
                r_spike_id <= w_gnt_idx;
            end
        end
    end

    assign spike_out  = r_spike_out;
    assign spike_id   = r_spike_id;
    assign drop_pulse = r_drop_pulse;

`ifdef SYN_DROP_COUNT_EN
    logic [7:0] r_drop_count;
    logic [3:0] w_drop_n;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] n);
        logic [8:0] s;
        s = {1'b0, a} + {5'b0, n};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // Number of channels dropping a spike this cycle.
    always_comb begin
        w_drop_n = '0;
        for (int i = 0; i < N_IN; i++) begin
            w_drop_n = w_drop_n + 4'(w_drop[i]);
        end
    end

    // Saturating total of dropped spikes since reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_count <= '0;
        end else begin
            r_drop_count <= sat_add8(r_drop_count, w_drop_n);
        end
    end

    assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_synapse_scheduler.sv
// Testbench for synapse_scheduler: directed scenarios plus a randomized run,
// all compared against a time-based behavioural model of spike delivery.
module tb_synapse_scheduler;
    localparam int N  = 4;
    localparam int DW = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  spike_in;
    logic          cfg_we;
    logic [IW-1:0] cfg_addr;
    logic [DW-1:0] cfg_delay;
    logic          spike_out;
    logic [IW-1:0] spike_id;
    logic [N-1:0]  busy;
    logic          drop_pulse;
`ifdef SYN_DROP_COUNT_EN
    logic [7:0]    drop_count;
`endif

    synapse_scheduler #(.N_IN(N), .DELAY_W(DW), .ID_W(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spike_in   (spike_in),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_delay  (cfg_delay),
        .spike_out  (spike_out),
        .spike_id   (spike_id),
        .busy       (busy),
        .drop_pulse (drop_pulse)
`ifdef SYN_DROP_COUNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: a channel is "pending" from acceptance until its grant; it may
    // be granted from cycle rel onward.
    bit            m_pend [N];
    int            m_rel  [N];
    int            m_dly  [N];
    logic [N-1:0]  m_prev;
    int            m_ptr;
    int            m_cyc = 0;
    logic          m_out;
    logic [IW-1:0] m_id;
    logic          m_drop;
    int            m_cnt;
    logic [N-1:0]  m_busy;

`ifdef SYN_DROP_COUNT_EN
    logic [1+IW+N+1+8-1:0] obs, expv;
    assign obs  = {spike_out, spike_id, busy, drop_pulse, drop_count};
    assign expv = {m_out, m_id, m_busy, m_drop, 8'(m_cnt)};
`else
    logic [1+IW+N+1-1:0] obs, expv;
    assign obs  = {spike_out, spike_id, busy, drop_pulse};
    assign expv = {m_out, m_id, m_busy, m_drop};
`endif

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_rel[i]  = 0;
            m_dly[i]  = 0;
        end
        m_prev = '0;
        m_ptr  = N - 1;
        m_out  = 1'b0;
        m_id   = '0;
        m_drop = 1'b0;
        m_cnt  = 0;
        m_busy = '0;
    endtask

    task automatic model_step(input logic [N-1:0] s, input logic we,
                              input logic [IW-1:0] a, input logic [DW-1:0] d);
        int g;
        int nd;
        int idx;
        logic [N-1:0] acc;
        g = -1; nd = 0; acc = '0;
        for (int k = 1; k <= N; k++) begin
            idx = (m_ptr + k) % N;
            if (g < 0 && m_pend[idx] && m_rel[idx] <= m_cyc) g = idx;
        end
        for (int i = 0; i < N; i++) begin
            if (s[i] && !m_prev[i]) begin
                if (m_pend[i]) nd++;
                else acc[i] = 1'b1;
            end
        end
        if (g >= 0) begin
            m_pend[g] = 1'b0;
            m_ptr     = g;
            m_out     = 1'b1;
            m_id      = IW'(g);
        end else begin
            m_out = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                m_pend[i] = 1'b1;
                m_rel[i]  = m_cyc + 1 + m_dly[i];
            end
        end
        if (we) m_dly[a] = int'(d);
        m_prev = s;
        m_drop = (nd > 0);
        m_cnt  = (m_cnt + nd > 255) ? 255 : m_cnt + nd;
        m_cyc++;
        for (int i = 0; i < N; i++) m_busy[i] = m_pend[i];
    endtask

    // Drive one cycle of inputs, advance the model, land on the next negedge.
    task automatic tick(input logic [N-1:0] s, input logic we,
                        input logic [IW-1:0] a, input logic [DW-1:0] d);
        spike_in  = s;
        cfg_we    = we;
        cfg_addr  = a;
        cfg_delay = d;
        model_step(s, we, a, d);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        spike_in = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_delay = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        spike_in = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_delay = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_async obs=%h required=0", obs);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick('0, 1'b0, '0, '0);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL reset_idle n=%0d obs=%h exp=%h", n, obs, expv);
            end
        end
    endtask

    task automatic test_single_delay();
        int lat;
        lat = -1;
        do_reset();
        tick('0, 1'b1, 2'd0, 4'd3);
        for (int n = 0; n <= 8; n++) begin
            tick((n == 0) ? 4'b0001 : 4'b0000, 1'b0, '0, '0);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL single_delay n=%0d obs=%h exp=%h", n, obs, expv);
            end
            if (spike_out && lat < 0) lat = n;
        end
        checks++;
        if (lat !== 4 || spike_id !== 2'd0) begin
            errors++;
            $display("FAIL single_delay_latency got=%0d id=%0d required=4 id=0", lat, spike_id);
        end
    endtask

    task automatic test_zero_delay();
        int lat;
        lat = -1;
        do_reset();
        tick('0, 1'b1, 2'd2, 4'd0);
        for (int n = 0; n <= 4; n++) begin
            tick((n == 0) ? 4'b0100 : 4'b0000, 1'b0, '0, '0);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL zero_delay n=%0d obs=%h exp=%h", n, obs, expv);
            end
            if (spike_out && lat < 0) begin
                lat = n;
                checks++;
                if (spike_id !== 2'd2) begin
                    errors++;
                    $display("FAIL zero_delay_id got=%0d required=2", spike_id);
                end
            end
        end
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL zero_delay_latency got=%0d required=1", lat);
        end
    endtask

    task automatic test_all_at_once();
        int ids[$];
        do_reset();
        for (int n = 0; n <= 7; n++) begin
            tick((n == 0) ? 4'b1111 : 4'b0000, 1'b0, '0, '0);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL all_at_once n=%0d obs=%h exp=%h", n, obs, expv);
            end
            if (spike_out) ids.push_back(int'(spike_id));
        end
        checks++;
        if (ids.size() != 4) begin
            errors++;
            $display("FAIL all_at_once_count got=%0d required=4", ids.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (ids[k] != k) begin
                    errors++;
                    $display("FAIL all_at_once_order slot=%0d got=%0d required=%0d", k, ids[k], k);
                end
            end
        end
    endtask

    task automatic test_drop();
        int nd;
        int ns;
        nd = 0; ns = 0;
        do_reset();
        tick('0, 1'b1, 2'd1, 4'd5);
        for (int n = 0; n <= 10; n++) begin
            tick((n == 0 || n == 2) ? 4'b0010 : 4'b0000, 1'b0, '0, '0);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL drop n=%0d obs=%h exp=%h", n, obs, expv);
            end
            if (drop_pulse) nd++;
            if (spike_out && spike_id == 2'd1) ns++;
        end
        checks++;
        if (nd != 1 || ns != 1) begin
            errors++;
            $display("FAIL drop_counts drops=%0d spikes=%0d required=1 and 1", nd, ns);
        end
`ifdef SYN_DROP_COUNT_EN
        checks++;
        if (drop_count !== 8'd1) begin
            errors++;
            $display("FAIL drop_count got=%0d required=1", drop_count);
        end
`endif
    endtask

    task automatic test_delay_change();
        int lat1;
        int lat2;
        lat1 = -1; lat2 = -1;
        do_reset();
        tick('0, 1'b1, 2'd3, 4'd6);
        for (int n = 0; n <= 10; n++) begin
            tick((n == 0) ? 4'b1000 : 4'b0000, (n == 2), 2'd3, 4'd2);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL delay_change1 n=%0d obs=%h exp=%h", n, obs, expv);
            end
            if (spike_out && lat1 < 0) lat1 = n;
        end
        for (int n = 0; n <= 6; n++) begin
            tick((n == 0) ? 4'b1000 : 4'b0000, 1'b0, '0, '0);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL delay_change2 n=%0d obs=%h exp=%h", n, obs, expv);
            end
            if (spike_out && lat2 < 0) lat2 = n;
        end
        checks++;
        if (lat1 !== 7 || lat2 !== 3) begin
            errors++;
            $display("FAIL delay_change_latency got=%0d,%0d required=7,3", lat1, lat2);
        end
    endtask

    task automatic test_reset_mid();
        int ns;
        int first;
        ns = 0; first = -1;
        do_reset();
        tick('0, 1'b1, 2'd0, 4'd2);
        tick('0, 1'b1, 2'd1, 4'd6);
        for (int n = 0; n <= 2; n++) begin
            tick((n == 0) ? 4'b0011 : 4'b0000, 1'b0, '0, '0);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL reset_mid_pre n=%0d obs=%h exp=%h", n, obs, expv);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (spike_out !== 1'b0 || busy !== '0 || drop_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async out=%b busy=%b drop=%b required=0", spike_out, busy, drop_pulse);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n <= 9; n++) begin
            tick('0, 1'b0, '0, '0);
            if (spike_out) ns++;
        end
        checks++;
        if (ns != 0) begin
            errors++;
            $display("FAIL reset_mid_nospike got=%0d required=0", ns);
        end
        for (int n = 0; n <= 4; n++) begin
            tick((n == 0) ? 4'b0011 : 4'b0000, 1'b0, '0, '0);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL reset_mid_post n=%0d obs=%h exp=%h", n, obs, expv);
            end
            if (spike_out && first < 0) first = int'(spike_id);
        end
        checks++;
        if (first != 0) begin
            errors++;
            $display("FAIL reset_mid_first got=%0d required=0", first);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] s;
        s = '0;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 2) == 0) s = N'($urandom);
            tick(s, ($urandom_range(0, 3) == 0), IW'($urandom),
                 DW'($urandom_range(0, 6)));
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL random n=%0d obs=%h exp=%h", n, obs, expv);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        spike_in = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_delay = '0;
        model_reset();
        test_reset();
        test_single_delay();
        test_zero_delay();
        test_all_at_once();
        test_drop();
        test_delay_change();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/synapse_scheduler.md
Name: synapse_scheduler

Overview:
- Sequences spike delivery from N_IN presynaptic lines onto one shared postsynaptic spike line.
- Each input channel has a programmable axonal delay.
- A per-channel FSM holds each spike for its delay. A round-robin arbiter then serialises expired spikes onto spike_out, tagged with the source channel ID.
- Sits between the presynaptic neuron array and a single postsynaptic neuron.

Parameters:
N_IN, 4, number of presynaptic input channels (2..8)
DELAY_W, 4, width of each channel delay register and counter
ID_W, 2, width of channel ID; must equal clog2(N_IN)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
spike_in  input  N_IN  presynaptic spike levels, synchronous to clk; bit i = channel i
cfg_we  input  1  delay register write strobe
cfg_addr  input  ID_W  channel selected by the write
cfg_delay  input  DELAY_W  delay value in clk cycles
spike_out  output  1  one-cycle postsynaptic spike pulse, registered
spike_id  output  ID_W  source channel of current spike_out; holds last value otherwise
busy  output  N_IN  bit i high while channel i is in DELAY or READY
drop_pulse  output  1  one-cycle pulse: a spike edge arrived on a busy channel

Behaviour:
- Reset, asynchronous, rst_n low:
  - All channels IDLE; counters 0; delay registers 0; prev-input register 0.
  - spike_out=0, spike_id=0, busy=0, drop_pulse=0.
  - RR pointer = N_IN-1, so channel 0 has first priority.
- Edge detect: edge[i] = spike_in[i] & ~prev[i]; prev is spike_in registered every cycle. A level held high produces one edge only.
- Delay registers:
  - cfg_we writes cfg_delay into delay[cfg_addr] at the clock edge.
  - A channel already in DELAY keeps its loaded count; the new value applies from the next spike.
  - Write and edge on the same channel in the same cycle: the old delay value is loaded.
- Per-channel FSM, states IDLE, DELAY, READY:
  - IDLE, edge[i]: if delay[i]==0 go to READY, else go to DELAY with cnt=delay[i].
  - DELAY: cnt decrements every cycle; on the edge where cnt==1, go to READY with cnt=0.
  - READY: request the arbiter. When granted, go to IDLE on the same edge that registers spike_out.
  - edge[i] while in DELAY or READY: spike dropped, state untouched, drop_pulse=1 next cycle.
  - The same cycle in which a channel leaves READY→IDLE still counts as busy, so an edge then is dropped.
- Arbiter:
  - At most one grant per cycle, round-robin.
  - Search starts at pointer+1 and wraps modulo N_IN; pointer updates to the granted index.
  - With no request: no grant, pointer unchanged.
- Output:
  - A grant in cycle c gives spike_out=1 and spike_id=granted index after the edge ending c, for exactly one cycle.
- Latency with no contention, edge sampled at clock edge t:
  - Channel enters READY after edge t+D.
  - spike_out is high during the cycle following edge t+D+1; that is D+1 cycles.
  - D=0 gives 1 cycle.
- Contention:
  - A READY channel waits with no loss; worst-case extra wait is N_IN-1 cycles.
  - Every accepted spike is delivered exactly once.
- busy[i] is combinational from state (state != IDLE).
- drop_pulse is registered; simultaneous drops on several channels give one pulse.
- Reset mid-operation discards all pending spikes and emits no spike_out.

Optional Feature:
- Macro SYN_DROP_COUNT_EN.
- When defined:
  - Adds output drop_count, width 8: a saturating count of dropped spikes since reset.
  - Multiple drops in one cycle add their number, saturating at 255.
  - Reset value is 0.
- When undefined: the port and counter are absent; drop_pulse is unchanged.

Test Plan:
- Reset, write delay[0]=3, single pulse on spike_in[0] sampled at edge t -> spike_out=1, spike_id=0 for one cycle after edge t+4; busy[0] high from t to t+4.
- delay[2]=0, edge on channel 2 -> spike_out pulse 1 cycle after edge, spike_id=2.
- All delays 0, spike_in=4'b1111 in one cycle after reset -> four consecutive spike_out pulses with spike_id order 0,1,2,3, none lost.
- delay[1]=5, second edge on channel 1 while in DELAY -> drop_pulse once, exactly one spike_out with id 1; with SYN_DROP_COUNT_EN, drop_count=1.
- delay[3]=6, write delay[3]=2 two cycles after channel 3 enters DELAY -> first spike still 7 cycles; next spike 3 cycles.
- Assert rst_n low while channels 0 and 1 are READY/DELAY -> outputs 0 immediately, no later spike_out; channel 0 wins first after release.
